// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and the
// counter-width helper used to size the bit counter.
// No ports; imported by serial_add_ctrl.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2 with a floor of 1, so a counter always has at least one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder, purely combinational.
// Ports: A, B, Ci (addend bits and carry-in) -> S (sum bit), Co (carry-out).
// Zero latency; no state, no flow control.
module fa_cell (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic S,
  output logic Co
);

  logic p;

  assign p  = A ^ B;
  assign S  = p ^ Ci;
  assign Co = (A & B) | (Ci & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial ripple-carry adder: one fa_cell reused LSB-first, one bit per clock.
// Ports: clk/rst_n; in_valid/in_ready with a, b, cin; out_valid/out_ready with
// sum, cout (registered, held while out_valid); busy high in RUN or DONE.
// Latency WIDTH cycles from accept to out_valid; one op per WIDTH+2 cycles.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = clog2_min1(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             s, co;
  logic [WIDTH-1:0] sum_next;

  fa_cell u_fa (
    .A  (a_sh[0]),
    .B  (b_sh[0]),
    .Ci (carry),
    .S  (s),
    .Co (co)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign sum_next = {s, sum_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sh <= '0;
          end
        end
        RUN: begin
          sum_sh <= sum_next;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          carry  <= co;
          cnt    <= cnt + CNT_W'(1);
          // sum/cout are only updated here, so they hold after DONE exits.
          if (cnt == LAST) begin
            sum  <= sum_next;
            cout <= co;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
